// File: rtl/cnn_acc_requant_if.sv
// Stream bundle for cnn_acc_requant: bias + product input stream, requantized output stream.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface cnn_acc_requant_if #(
  parameter int PROD_W = 24,
  parameter int OUT_W  = 14,
  parameter int ACC_W  = 32
);
  logic signed [ACC_W-1:0]  bias_in;
  logic signed [PROD_W-1:0] prod_tdata;
  logic                     prod_tvalid;
  logic                     prod_tready;
  logic signed [OUT_W-1:0]  out_tdata;
  logic                     out_tvalid;
  logic                     out_tready;
  logic                     out_sat;

  modport slave (
    input  bias_in,
    input  prod_tdata,
    input  prod_tvalid,
    output prod_tready,
    output out_tdata,
    output out_tvalid,
    input  out_tready,
    output out_sat
  );

  modport master (
    output bias_in,
    output prod_tdata,
    output prod_tvalid,
    input  prod_tready,
    input  out_tdata,
    input  out_tvalid,
    output out_tready,
    input  out_sat
  );
endinterface

// File: rtl/cnn_acc_requant.sv
// Accumulates NUM_TERMS signed products onto a bias, then requantizes (round-half-up shift + saturate).
// Optional macro CNN_ACC_REQUANT_RELU_EN clamps negative results to zero after saturation.
module cnn_acc_requant #(
  parameter int PROD_W     = 24,
  parameter int OUT_W      = 14,
  parameter int ACC_W      = 32,
  parameter int NUM_TERMS  = 25,
  parameter int FRAC_SHIFT = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  cnn_acc_requant_if.slave  s_if
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TERMS - 1);

  // Rounding constant and clip limits, all in the widened ACC_W+1 domain.
  localparam logic signed [ACC_W:0] RND_HALF =
    {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_QUANT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_prod_tready;
  logic signed [OUT_W-1:0] r_out_tdata;
  logic                    r_out_tvalid;
  logic                    r_out_sat;

  logic                    w_accept;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_acc_base;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W:0]   w_acc_wide;
  logic signed [ACC_W:0]   w_rounded;
  logic signed [ACC_W:0]   w_shifted;
  logic                    w_clip_hi;
  logic                    w_clip_lo;
  logic signed [OUT_W-1:0] w_q_data;
  logic                    w_q_sat;

  // Handshake uses the registered ready, so there is no path from prod_tvalid to prod_tready.
  assign w_accept = (r_state == ST_ACC) && r_prod_tready && s_if.prod_tvalid;
  assign w_last   = (r_cnt == CNT_LAST);

  assign w_prod_ext = {{(ACC_W - PROD_W){s_if.prod_tdata[PROD_W-1]}}, s_if.prod_tdata};
  assign w_acc_base = (r_cnt == '0) ? s_if.bias_in : r_acc;
  assign w_acc_next = w_acc_base + w_prod_ext;

  // One extra bit keeps the rounding add from wrapping at the accumulator's top end.
  assign w_acc_wide = {r_acc[ACC_W-1], r_acc};
  assign w_rounded  = w_acc_wide + RND_HALF;
  assign w_shifted  = w_rounded >>> FRAC_SHIFT;
  assign w_clip_hi  = (w_shifted > SAT_MAX);
  assign w_clip_lo  = (w_shifted < SAT_MIN);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_q_data = w_shifted[OUT_W-1:0];
    w_q_sat  = w_clip_hi | w_clip_lo;
    if (w_clip_hi) begin
      w_q_data = OUT_MAX;
    end else if (w_clip_lo) begin
      w_q_data = OUT_MIN;
    end
`ifdef CNN_ACC_REQUANT_RELU_EN
    // Negative clips vanish under ReLU, so only positive clipping is reported.
    if (w_q_data[OUT_W-1]) begin
      w_q_data = '0;
    end
    w_q_sat = w_clip_hi;
`else
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= ST_ACC;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_prod_tready <= 1'b0;
      r_out_tdata   <= '0;
      r_out_tvalid  <= 1'b0;
      r_out_sat     <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          r_prod_tready <= 1'b1;
          if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_last) begin
              r_cnt         <= '0;
              r_prod_tready <= 1'b0;
              r_state       <= ST_QUANT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_QUANT: begin
          r_out_tdata  <= w_q_data;
          r_out_sat    <= w_q_sat;
          r_out_tvalid <= 1'b1;
          r_state      <= ST_OUT;
        end

        ST_OUT: begin
          // Result and flag stay frozen until the consumer takes them.
          if (s_if.out_tready) begin
            r_out_tvalid  <= 1'b0;
            r_prod_tready <= 1'b1;
            r_state       <= ST_ACC;
          end
        end

        default: begin
          r_state       <= ST_ACC;
          r_cnt         <= '0;
          r_prod_tready <= 1'b0;
          r_out_tvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.prod_tready = r_prod_tready;
  assign s_if.out_tdata   = r_out_tdata;
  assign s_if.out_tvalid  = r_out_tvalid;
  assign s_if.out_sat     = r_out_sat;

endmodule

// File: tb/tb_cnn_acc_requant.sv
// Directed bench for cnn_acc_requant (NUM_TERMS=4, FRAC_SHIFT=8, OUT_W=14, PROD_W=24, ACC_W=32).
// Table of groups plus hand-written latency, gap, backpressure and reset sequences.
module tb_cnn_acc_requant;

  localparam int PROD_W     = 24;
  localparam int OUT_W      = 14;
  localparam int ACC_W      = 32;
  localparam int NUM_TERMS  = 4;
  localparam int FRAC_SHIFT = 8;

  typedef struct {
    string                    name;
    logic signed [ACC_W-1:0]  bias;
    logic signed [PROD_W-1:0] p0;
    logic signed [PROD_W-1:0] p1;
    logic signed [PROD_W-1:0] p2;
    logic signed [PROD_W-1:0] p3;
    int                       exp_data;
    int                       exp_sat;
  } vec_t;

  logic ap_clk;
  logic ap_rst_n;
  int   n_cmp;
  int   n_fail;

  cnn_acc_requant_if #(.PROD_W(PROD_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) bus ();

  cnn_acc_requant #(
    .PROD_W(PROD_W), .OUT_W(OUT_W), .ACC_W(ACC_W),
    .NUM_TERMS(NUM_TERMS), .FRAC_SHIFT(FRAC_SHIFT)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .s_if    (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Presents n products (one per accept); optionally drops valid for gap_len cycles before index gap_after.
  task automatic feed(input logic signed [ACC_W-1:0] bias,
                      input logic signed [PROD_W-1:0] p0, input logic signed [PROD_W-1:0] p1,
                      input logic signed [PROD_W-1:0] p2, input logic signed [PROD_W-1:0] p3,
                      input int n, input int gap_after, input int gap_len);
    logic signed [PROD_W-1:0] p [4];
    int   i;
    int   budget;
    logic rdy;
    p      = '{p0, p1, p2, p3};
    i      = 0;
    budget = 0;
    while (i < n && budget < 200) begin
      if (i == gap_after && gap_len > 0) begin
        bus.prod_tvalid = 1'b0;
        repeat (gap_len) begin
          @(negedge ap_clk);
          check("gap_ready_held", int'(bus.prod_tready), 1);
          @(posedge ap_clk);
          #1;
        end
        gap_after = -1;
      end
      bus.bias_in     = bias;
      bus.prod_tdata  = p[i];
      bus.prod_tvalid = 1'b1;
      @(negedge ap_clk);
      rdy = bus.prod_tready;
      @(posedge ap_clk);
      #1;
      if (rdy) i++;
      budget++;
    end
    bus.prod_tvalid = 1'b0;
    check("feed_accepts", i, n);
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge ap_clk);
      ok = bus.out_tvalid;
    end
  endtask

  // Waits for a result, samples it at the negedge, then lets the handshake edge pass.
  task automatic collect(output int data, output int sat);
    logic ok;
    wait_valid(ok);
    check("collect_valid_seen", int'(ok), 1);
    data = int'(bus.out_tdata);
    sat  = int'(bus.out_sat);
    @(posedge ap_clk);
    #1;
  endtask

  vec_t vecs [8];
  int   d;
  int   s;
  logic ok;

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{"basic_256x4",  32'sd0,   24'sd256, 24'sd256, 24'sd256, 24'sd256, 4, 0};
    vecs[1] = '{"round_up_half", 32'sd0,  24'sd128, 24'sd0,   24'sd0,   24'sd0,   1, 0};
    vecs[2] = '{"round_neg_half", 32'sd0, -24'sd128, 24'sd0,  24'sd0,   24'sd0,   0, 0};
    vecs[3] = '{"bias_512",     32'sd512, 24'sd0,   24'sd0,   24'sd0,   24'sd0,   2, 0};
    vecs[4] = '{"sat_max",      32'sd0,   24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 8191, 1};
`ifdef CNN_ACC_REQUANT_RELU_EN
    vecs[5] = '{"sat_min",      32'sd0,   24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000, 0, 0};
    vecs[6] = '{"neg_256x4",    32'sd0,   -24'sd256, -24'sd256, -24'sd256, -24'sd256, 0, 0};
`else
    vecs[5] = '{"sat_min",      32'sd0,   24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000, -8192, 1};
    vecs[6] = '{"neg_256x4",    32'sd0,   -24'sd256, -24'sd256, -24'sd256, -24'sd256, -4, 0};
`endif
    vecs[7] = '{"mixed_bias",   -32'sd300, 24'sd1000, -24'sd200, 24'sd50, 24'sd10, 2, 0};

    ap_rst_n        = 1'b0;
    bus.bias_in     = '0;
    bus.prod_tdata  = '0;
    bus.prod_tvalid = 1'b0;
    bus.out_tready  = 1'b1;

    // Reset state, including one clock edge with reset still held.
    #2;
    check("rst_out_tdata",   int'(bus.out_tdata),   0);
    check("rst_out_tvalid",  int'(bus.out_tvalid),  0);
    check("rst_out_sat",     int'(bus.out_sat),     0);
    check("rst_prod_tready", int'(bus.prod_tready), 0);
    @(posedge ap_clk);
    #1;
    check("rst_ready_held_low", int'(bus.prod_tready), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("ready_after_release", int'(bus.prod_tready), 1);

    // Latency / throughput: valid visible after the edge following the last accept, ready low 2 cycles.
    feed(32'sd0, 24'sd256, 24'sd256, 24'sd256, 24'sd256, 4, -1, 0);
    check("lat_valid_low_quant", int'(bus.out_tvalid),  0);
    check("lat_ready_low_quant", int'(bus.prod_tready), 0);
    @(posedge ap_clk);
    #1;
    check("lat_valid_high",      int'(bus.out_tvalid),  1);
    check("lat_data",            int'(bus.out_tdata),   4);
    check("lat_sat",             int'(bus.out_sat),     0);
    check("lat_ready_low_out",   int'(bus.prod_tready), 0);
    @(posedge ap_clk);
    #1;
    check("lat_valid_dropped",   int'(bus.out_tvalid),  0);
    check("lat_ready_back",      int'(bus.prod_tready), 1);

    for (int k = 0; k < 8; k++) begin
      feed(vecs[k].bias, vecs[k].p0, vecs[k].p1, vecs[k].p2, vecs[k].p3, 4, -1, 0);
      collect(d, s);
      check({vecs[k].name, "_data"}, d, vecs[k].exp_data);
      check({vecs[k].name, "_sat"},  s, vecs[k].exp_sat);
    end

    // Three idle cycles between 2nd and 3rd product: (1000 + 128) >>> 8 = 4.
    feed(32'sd0, 24'sd100, 24'sd200, 24'sd300, 24'sd400, 4, 2, 3);
    collect(d, s);
    check("gap_data", d, 4);
    check("gap_sat",  s, 0);

    // Backpressure: (1200 + 128) >>> 8 = 5 held for 10 cycles while a new product waits.
    bus.out_tready = 1'b0;
    feed(32'sd0, 24'sd300, 24'sd300, 24'sd300, 24'sd300, 4, -1, 0);
    wait_valid(ok);
    check("bp_valid_seen", int'(ok), 1);
    bus.bias_in     = 32'sd0;
    bus.prod_tdata  = 24'sd256;
    bus.prod_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid_held", int'(bus.out_tvalid),  1);
      check("bp_data_held",  int'(bus.out_tdata),   5);
      check("bp_sat_held",   int'(bus.out_sat),     0);
      check("bp_ready_low",  int'(bus.prod_tready), 0);
      @(negedge ap_clk);
    end
    bus.out_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    check("bp_valid_cleared", int'(bus.out_tvalid),  0);
    check("bp_ready_resumed", int'(bus.prod_tready), 1);
    // The waiting product must open the next group, so the result is 1024 -> 4, not contaminated.
    feed(32'sd0, 24'sd256, 24'sd256, 24'sd256, 24'sd256, 4, -1, 0);
    collect(d, s);
    check("bp_next_group_data", d, 4);

    // Reset mid-group: two products of 1000 are discarded; last out_tdata (4) must clear at once.
    feed(32'sd0, 24'sd1000, 24'sd1000, 24'sd0, 24'sd0, 2, -1, 0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_out_tdata",   int'(bus.out_tdata),   0);
    check("mid_rst_out_tvalid",  int'(bus.out_tvalid),  0);
    check("mid_rst_out_sat",     int'(bus.out_sat),     0);
    check("mid_rst_prod_tready", int'(bus.prod_tready), 0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    feed(32'sd0, 24'sd256, 24'sd256, 24'sd256, 24'sd256, 4, -1, 0);
    collect(d, s);
    check("post_rst_data", d, 4);
    check("post_rst_sat",  s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
